crc_frame_serializer: RTL
=========================

// Module: crc_frame_serializer
// PURPOSE
//  Upstream feeder for the bit-serial CRC-16 (CDMA2000, poly 0xC867) calculator.
//  Accepts payload bytes over a valid/ready stream and shifts them MSB-first into the calculator.
//  Then appends CRC_W augmentation zero bits and drives read mode to pull the CRC back out.
//  Emits one serial TX stream: payload bits followed by the CRC bits. Sits between the byte source and the line driver.
// PARAMETERS
//  DATA_W  8   payload word width in bits
//  CRC_W   16  CRC width: number of flush cycles and number of read cycles
// PORTS
//  CLK            in   1       system clock, rising edge
//  RESET          in   1       asynchronous, active-high reset
//  S_DATA         in   DATA_W  payload word
//  S_VALID        in   1       S_DATA valid
//  S_LAST         in   1       S_DATA is the final word of the frame
//  S_READY        out  1       block accepts S_DATA this cycle
//  CRC_RESET_N    out  1       to calculator RESET_N; registered; low holds the CRC at 0xFFFF
//  CRC_DATA_IN    out  1       to calculator DATA_IN; registered
//  CRC_READ_MODE  out  1       to calculator READ_MODE; registered
//  CRC_BIT        in   1       from calculator CRC_OUT; lags CRC_READ_MODE by 1 cycle
//  TX_BIT         out  1       serial output bit
//  TX_VALID       out  1       TX_BIT is a frame bit
//  TX_SOF/TX_EOF  out  1       pulse on first payload bit / last CRC bit
//  TX_ABORT       out  1       1-cycle pulse: frame dropped on underrun
//  BUSY           out  1       state != IDLE
// BEHAVIOUR
//  Reset
//  - RESET asserted: all outputs go to 0, including CRC_RESET_N=0; S_READY=0; FSM=IDLE.
//  - S_READY rises 1 cycle after RESET deasserts.
//  - RESET mid-frame aborts immediately. No TX_EOF or TX_ABORT is produced.
//  FSM
//  - IDLE: CRC_RESET_N=0, S_READY=1.
//    - S_VALID&S_READY: latch word and last flag; bit counter cnt=0; go to SHIFT.
//  - SHIFT: each cycle drive one payload bit.
//    - CRC_DATA_IN=TX_BIT=bit; TX_VALID=1; CRC_RESET_N=1.
//    - First bit of the frame is registered out in the cycle after acceptance.
//    - On the last bit (cnt==DATA_W-1) with last flag clear: S_READY=1.
//      - S_VALID=1: load the next word; continue SHIFT with zero gap.
//      - S_VALID=0: underrun. The calculator has no enable, so a gap would corrupt the CRC.
//        Pulse TX_ABORT; go to IDLE; CRC returns to 0xFFFF.
//    - Last bit with last flag set: go to FLUSH.
//  - FLUSH: CRC_W cycles of CRC_DATA_IN=0; TX_VALID=0.
//  - READ: CRC_W cycles with CRC_READ_MODE=1.
//  - DRAIN: 1 cycle with CRC_READ_MODE=0; TX_EOF=1; then go to IDLE.
//  CRC bit output
//  - CRC_BIT is valid from READ cycle 1 through DRAIN.
//  - In those cycles TX_BIT=CRC_BIT, unregistered pass-through, and TX_VALID=1.
//  - Result: exactly CRC_W contiguous CRC bits.
//  Frame timing
//  - N words occupy N*DATA_W + 2*CRC_W + 1 cycles after acceptance, then 1 cycle in IDLE.
//  - TX_VALID is low during FLUSH and READ cycle 0. This is a CRC_W+1 cycle gap.
//  Boundaries
//  - S_VALID is ignored outside the S_READY windows.
//  - S_LAST on the first word gives a 1-word frame.
//  - cnt wraps 0..DATA_W-1 in SHIFT and 0..CRC_W-1 in FLUSH and READ.
// CONFIGURATION
//  SERIAL_LSB_FIRST_EN
//  - Defined: payload bits are shifted LSB-first.
//  - Undefined (default): MSB-first. CRC bits are always MSB-first.
// STRUCTURE
//  crc_serial_pkg holds:
//  - typedef enum {IDLE,SHIFT,FLUSH,READ,DRAIN} ser_state_t
//  - constants CRC16_CDMA2000_POLY=16'hC867 and CRC16_INIT=16'hFFFF
//  One natural sub-module: crc_frame_serializer_shreg (DATA_W load/shift register with bit-order select).
// TESTING
//  Checks use a golden model: augmented-form 0xC867 CRC, init 0xFFFF.
//  - 1 word 0xA5, S_LAST=1, MSB-first:
//    -> TX_BIT 1,0,1,0,0,1,0,1 on cycles 1-8; 17-cycle TX_VALID gap; 16 CRC bits = model; TX_EOF on the 16th.
//  - 3 words 0x12,0x34,0x56 back-to-back:
//    -> 24 contiguous payload bits with no gap; S_READY high only on cycles 8, 16, and in IDLE; CRC = model.
//  - 2-word frame with S_VALID low on cycle 8:
//    -> TX_ABORT pulse on cycle 8; IDLE next cycle; the following 1-word frame's CRC matches the model.
//  - RESET asserted in READ cycle 5:
//    -> all outputs 0 asynchronously; no TX_EOF; next frame correct.
//  - SERIAL_LSB_FIRST_EN defined, word 0x01:
//    -> TX_BIT 1,0,0,0,0,0,0,0; CRC matches the LSB-first model.
//  - Two frames back-to-back: the second is accepted on the IDLE cycle after DRAIN; both CRCs match.

Source files
------------

// File: rtl/crc_serial_pkg.sv
// Shared types and constants for the CRC-16/CDMA2000 serial frame path.
package crc_serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    FLUSH = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4
  } ser_state_t;

  localparam logic [15:0] CRC16_CDMA2000_POLY = 16'hC867;
  localparam logic [15:0] CRC16_INIT          = 16'hFFFF;

endpackage

// File: rtl/crc_frame_serializer_shreg.sv
// Payload load/shift register; bit order is MSB-first unless SERIAL_LSB_FIRST_EN is defined.
module crc_frame_serializer_shreg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_head,
  output logic              o_next
);

  logic [DATA_W-1:0] r_sr;
  logic [DATA_W-1:0] w_load_val;
  logic [DATA_W-1:0] w_shift_val;

  // o_head goes out on the load edge, so the register keeps only the remaining bits.
`ifdef SERIAL_LSB_FIRST_EN
  assign o_head      = i_data[0];
  assign o_next      = r_sr[0];
  assign w_load_val  = i_data >> 1;
  assign w_shift_val = r_sr >> 1;
`else
  assign o_head      = i_data[DATA_W-1];
  assign o_next      = r_sr[DATA_W-1];
  assign w_load_val  = i_data << 1;
  assign w_shift_val = r_sr << 1;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= w_load_val;
    end else if (i_shift) begin
      r_sr <= w_shift_val;
    end
  end

endmodule

// File: rtl/crc_frame_serializer.sv
// Byte-stream to bit-serial feeder for the CRC-16/CDMA2000 calculator, emitting payload then CRC on TX.
// Build option: SERIAL_LSB_FIRST_EN selects LSB-first payload order (default MSB-first).
module crc_frame_serializer
  import crc_serial_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CRC_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] S_DATA,
  input  logic              S_VALID,
  input  logic              S_LAST,
  output logic              S_READY,
  output logic              CRC_RESET_N,
  output logic              CRC_DATA_IN,
  output logic              CRC_READ_MODE,
  input  logic              CRC_BIT,
  output logic              TX_BIT,
  output logic              TX_VALID,
  output logic              TX_SOF,
  output logic              TX_EOF,
  output logic              TX_ABORT,
  output logic              BUSY
);

  localparam int unsigned MAX_W = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int unsigned CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(CRC_W - 1);

  ser_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             r_alive;
  logic             r_crc_rst_n;
  logic             r_crc_data;
  logic             r_read_mode;
  logic             r_tx_bit;
  logic             r_tx_valid;
  logic             r_tx_sof;
  logic             r_tx_eof;

  logic w_head;
  logic w_next;
  logic w_idle_rdy;
  logic w_last_bit;
  logic w_mid_rdy;
  logic w_load;
  logic w_crc_phase;

  assign w_idle_rdy  = (r_state == IDLE) && r_alive;
  assign w_last_bit  = (r_state == SHIFT) && (r_cnt == LAST_DATA);
  assign w_mid_rdy   = w_last_bit && !r_last;
  assign w_load      = (w_idle_rdy || w_mid_rdy) && S_VALID;
  // Calculator output trails READ_MODE by one cycle, so the CRC window is READ cnt>=1 plus DRAIN.
  assign w_crc_phase = ((r_state == READ) && (r_cnt != '0)) || (r_state == DRAIN);

  assign S_READY       = w_idle_rdy || w_mid_rdy;
  assign TX_ABORT      = w_mid_rdy && !S_VALID;
  assign CRC_RESET_N   = r_crc_rst_n;
  assign CRC_DATA_IN   = r_crc_data;
  assign CRC_READ_MODE = r_read_mode;
  assign TX_BIT        = w_crc_phase ? CRC_BIT : r_tx_bit;
  assign TX_VALID      = r_tx_valid || w_crc_phase;
  assign TX_SOF        = r_tx_sof;
  assign TX_EOF        = r_tx_eof;
  assign BUSY          = (r_state != IDLE);

  crc_frame_serializer_shreg #(.DATA_W(DATA_W)) u_shreg (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_load  (w_load),
    .i_shift ((r_state == SHIFT) && !w_last_bit),
    .i_data  (S_DATA),
    .o_head  (w_head),
    .o_next  (w_next)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_alive     <= 1'b0;
      r_crc_rst_n <= 1'b0;
      r_crc_data  <= 1'b0;
      r_read_mode <= 1'b0;
      r_tx_bit    <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_sof    <= 1'b0;
      r_tx_eof    <= 1'b0;
    end else begin
      r_alive  <= 1'b1;
      r_tx_sof <= 1'b0;
      r_tx_eof <= 1'b0;
      case (r_state)
        IDLE: begin
          r_crc_rst_n <= 1'b0;
          if (w_load) begin
            r_state     <= SHIFT;
            r_cnt       <= '0;
            r_last      <= S_LAST;
            r_crc_rst_n <= 1'b1;
            r_crc_data  <= w_head;
            r_tx_bit    <= w_head;
            r_tx_valid  <= 1'b1;
            r_tx_sof    <= 1'b1;
          end
        end
        SHIFT: begin
          if (!w_last_bit) begin
            r_cnt      <= r_cnt + CNT_W'(1);
            r_crc_data <= w_next;
            r_tx_bit   <= w_next;
          end else if (r_last) begin
            r_state    <= FLUSH;
            r_cnt      <= '0;
            r_crc_data <= 1'b0;
            r_tx_bit   <= 1'b0;
            r_tx_valid <= 1'b0;
          end else if (S_VALID) begin
            r_cnt      <= '0;
            r_last     <= S_LAST;
            r_crc_data <= w_head;
            r_tx_bit   <= w_head;
          end else begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_crc_rst_n <= 1'b0;
            r_crc_data  <= 1'b0;
            r_tx_bit    <= 1'b0;
            r_tx_valid  <= 1'b0;
          end
        end
        FLUSH: begin
          if (r_cnt == LAST_CRC) begin
            r_state     <= READ;
            r_cnt       <= '0;
            r_read_mode <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        READ: begin
          if (r_cnt == LAST_CRC) begin
            r_state     <= DRAIN;
            r_cnt       <= '0;
            r_read_mode <= 1'b0;
            r_tx_eof    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          r_state     <= IDLE;
          r_crc_rst_n <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
